// File: rtl/if_pkg.sv
// Shared types and sizing helpers for the instruction-fetch prefetch unit.
package if_pkg;

  localparam int IF_XLEN         = 32;
  localparam int IF_ILEN         = 32;
  localparam int INSTR_BYTES_DEF = 4;
  localparam int DEPTH_DEF       = 4;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_ILEN-1:0] instr;
    logic               filled;
  } slot_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counters must be able to hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Redirect, instruction-memory and decode-side signals of the prefetch unit.
interface if_prefetch_unit_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_ready;

  // master: the prefetch unit; slave: memory, branch logic and decode.
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, out_ready,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/if_slot_queue.sv
// In-order slot storage: slots are allocated at tail, filled in order at the
// fill pointer and popped at head. Flush empties the queue in one cycle.
module if_slot_queue
  import if_pkg::*;
#(
  parameter int XLEN  = IF_XLEN,
  parameter int ILEN  = IF_ILEN,
  parameter int DEPTH = DEPTH_DEF,
  localparam int PW   = ptr_w(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_alloc,
  input  logic [XLEN-1:0] i_alloc_pc,
  input  logic            i_fill,
  input  logic [ILEN-1:0] i_fill_data,
  input  logic            i_pop,
  output logic [CW-1:0]   o_count,
  output logic [CW-1:0]   o_unfilled,
  output logic            o_head_valid,
  output logic [XLEN-1:0] o_head_pc,
  output logic [ILEN-1:0] o_head_instr
);

  logic [XLEN-1:0]  r_pc    [DEPTH];
  logic [ILEN-1:0]  r_instr [DEPTH];
  logic [DEPTH-1:0] r_filled;
  logic [PW-1:0]    r_head, r_tail, r_fill;
  logic [CW-1:0]    r_count, r_unfilled;
  logic             w_live;

  assign w_live = !i_rst && !i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
      r_filled   <= '0;
    end else if (i_flush) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_fill     <= '0;
      r_count    <= '0;
      r_unfilled <= '0;
    end else begin
      if (i_alloc) begin
        r_filled[r_tail] <= 1'b0;
        r_tail           <= r_tail + 1'b1;
      end
      if (i_fill) begin
        r_filled[r_fill] <= 1'b1;
        r_fill           <= r_fill + 1'b1;
      end
      if (i_pop)
        r_head <= r_head + 1'b1;
      r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
      r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
    end
  end

  // Payload storage needs no reset; validity lives in r_count/r_filled.
  always_ff @(posedge i_clk) begin
    if (w_live && i_alloc)
      r_pc[r_tail] <= i_alloc_pc;
    if (w_live && i_fill)
      r_instr[r_fill] <= i_fill_data;
  end

  assign o_count      = r_count;
  assign o_unfilled   = r_unfilled;
  assign o_head_valid = (r_count != '0) && r_filled[r_head];
  assign o_head_pc    = r_pc[r_head];
  assign o_head_instr = r_instr[r_head];

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order imem requests, buffers
// fetched instructions for decode and drops responses from flushed paths.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int              XLEN        = IF_XLEN,
  parameter int              ILEN        = IF_ILEN,
  parameter int              INSTR_BYTES = INSTR_BYTES_DEF,
  parameter int              DEPTH       = DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic               CLK,
  input  logic               rst,
  if_prefetch_unit_if.master bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_stale;
  logic            r_rst_q;

  logic [CW-1:0]   w_count, w_unfilled;
  logic [CW:0]     w_budget;
  logic            w_req_valid, w_accept;
  logic            w_head_valid, w_out_valid, w_pop;
  logic            w_stale_hit, w_fill;
  logic [XLEN-1:0] w_redirect_pc, w_head_pc;
  logic [ILEN-1:0] w_head_instr;

  assign w_redirect_pc = bus.redirect_pc & ~XLEN'(INSTR_BYTES - 1);

  // Stale responses still occupy memory-side capacity, so they share the budget.
  assign w_budget    = {1'b0, w_count} + {1'b0, r_stale};
  assign w_req_valid = !rst && !r_rst_q && !bus.redirect_valid &&
                       (w_budget < (CW+1)'(DEPTH));
  assign w_accept    = w_req_valid && bus.imem_req_ready;

  assign w_out_valid = w_head_valid && !rst;
  assign w_pop       = w_out_valid && bus.out_ready;

  assign w_stale_hit = bus.imem_rsp_valid && (r_stale != '0);
  assign w_fill      = bus.imem_rsp_valid && !w_stale_hit && !bus.redirect_valid;

  always_ff @(posedge CLK) begin
    r_rst_q <= rst;
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_stale    <= '0;
    end else if (bus.redirect_valid) begin
      // Every unfilled slot becomes an owed response; one arriving now is eaten.
      r_fetch_pc <= w_redirect_pc;
      r_stale    <= r_stale + w_unfilled - CW'(bus.imem_rsp_valid);
    end else begin
      if (w_accept)
        r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
      if (w_stale_hit)
        r_stale <= r_stale - 1'b1;
    end
  end

  if_slot_queue #(
    .XLEN  (XLEN),
    .ILEN  (ILEN),
    .DEPTH (DEPTH)
  ) u_q (
    .i_clk        (CLK),
    .i_rst        (rst),
    .i_flush      (bus.redirect_valid),
    .i_alloc      (w_accept),
    .i_alloc_pc   (r_fetch_pc),
    .i_fill       (w_fill),
    .i_fill_data  (bus.imem_rsp_data),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_unfilled   (w_unfilled),
    .o_head_valid (w_head_valid),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr)
  );

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_fetch_pc;
  assign bus.out_valid      = w_out_valid;
  assign bus.out_pc         = w_head_pc;
  assign bus.out_instr      = w_head_instr;

endmodule
